// File: rtl/muldiv_pkg.sv
// muldiv_pkg -- shared constants and helpers for the RV32M multiply/divide sequencer.
//   - FSM state encodings (legacy-compatible localparams)
//   - funct3 op selects (F3_MUL .. F3_REMU)
//   - divide special-case constants and helper functions
package muldiv_pkg;

   // FSM state encodings
   localparam logic [2:0] ST_IDLE = 3'd0;
   localparam logic [2:0] ST_MUL  = 3'd1;
   localparam logic [2:0] ST_DIV  = 3'd2;
   localparam logic [2:0] ST_FIX  = 3'd3;
   localparam logic [2:0] ST_DONE = 3'd4;

   // funct3 op selects for the OP opcode with funct7 = 0000001
   localparam logic [2:0] F3_MUL    = 3'd0;
   localparam logic [2:0] F3_MULH   = 3'd1;
   localparam logic [2:0] F3_MULHSU = 3'd2;
   localparam logic [2:0] F3_MULHU  = 3'd3;
   localparam logic [2:0] F3_DIV    = 3'd4;
   localparam logic [2:0] F3_DIVU   = 3'd5;
   localparam logic [2:0] F3_REM    = 3'd6;
   localparam logic [2:0] F3_REMU   = 3'd7;

   // Divide special-case constants
   localparam logic [31:0] DIV0_Q  = 32'hFFFF_FFFF;
   localparam logic [31:0] INT_MIN = 32'h8000_0000;
   localparam logic [31:0] NEG_ONE = 32'hFFFF_FFFF;

   // Two's-complement negation
   function automatic logic [31:0] neg32(input logic [31:0] v);
      return (~v) + 32'd1;
   endfunction

   // True for divide ops whose result is fixed by the ISA and needs no iteration.
   // funct3[0]=0 marks the signed divide ops (DIV, REM).
   function automatic logic is_special(input logic [2:0]  f3,
                                       input logic [31:0] a,
                                       input logic [31:0] b);
      return f3[2] && ((b == 32'd0) ||
                       (!f3[0] && (a == INT_MIN) && (b == NEG_ONE)));
   endfunction

   // Result for a special case; funct3[1]=1 selects the remainder ops.
   function automatic logic [31:0] special_result(input logic [2:0]  f3,
                                                  input logic [31:0] a,
                                                  input logic [31:0] b);
      logic [31:0] r;
      if (b == 32'd0) begin
         r = f3[1] ? a : DIV0_Q;
      end else begin
         r = f3[1] ? 32'd0 : INT_MIN;
      end
      return r;
   endfunction

endpackage

// File: rtl/div_step.sv
// div_step -- one combinational restoring-division step.
// The dividend is shifted out of the top of quo while quotient bits shift in at
// the bottom, so the FSM only needs the remainder/quotient pair plus the divisor.
// Ports:
//   rem      in  32  partial remainder (always < dvs)
//   quo      in  32  dividend bits not yet consumed / quotient bits so far
//   dvs      in  32  divisor magnitude (non-zero)
//   rem_nxt  out 32  partial remainder after this step
//   quo_nxt  out 32  quotient register after this step
module div_step
   import muldiv_pkg::*;
(
   input  logic [31:0] rem,
   input  logic [31:0] quo,
   input  logic [31:0] dvs,
   output logic [31:0] rem_nxt,
   output logic [31:0] quo_nxt
);

   logic [32:0] shifted_s;
   logic [32:0] diff_s;

   // Trial subtract. Since rem < dvs the shifted value is < 2*dvs, so bit 32 of
   // the difference is a clean "went negative" flag and a kept difference fits 32 bits.
   always_comb begin
      shifted_s = {rem, quo[31]};
      diff_s    = shifted_s - {1'b0, dvs};
      if (!diff_s[32]) begin
         rem_nxt = diff_s[31:0];
         quo_nxt = {quo[30:0], 1'b1};
      end else begin
         rem_nxt = shifted_s[31:0];
         quo_nxt = {quo[30:0], 1'b0};
      end
   end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq -- multi-cycle RV32M sequencer for the EXE stage.
// Runs a pipelined multiply or a 32-iteration restoring divide, stalls the front
// of the pipeline until the result is ready, then pulses done for one cycle.
// Ports:
//   clk      in  1     rising-edge clock
//   rst      in  1     asynchronous active-low reset
//   start    in  1     M-extension op valid in EXE
//   funct3   in  3     op select (MUL .. REMU)
//   rs1      in  XLEN  dividend / multiplicand
//   rs2      in  XLEN  divisor / multiplier
//   flush    in  1     kill the EXE instruction
//   stall_o  out 1     hold PC and front pipeline registers (combinational)
//   busy     out 1     FSM not idle (registered)
//   done     out 1     result valid for one cycle (registered)
//   result   out XLEN  result, held until the next completion
module muldiv_seq
   import muldiv_pkg::*;
#(
   parameter int XLEN    = 32,
   parameter int MUL_LAT = 2
)(
   input  logic            clk,
   input  logic            rst,
   input  logic            start,
   input  logic [2:0]      funct3,
   input  logic [XLEN-1:0] rs1,
   input  logic [XLEN-1:0] rs2,
   input  logic            flush,
   output logic            stall_o,
   output logic            busy,
   output logic            done,
   output logic [XLEN-1:0] result
);

   // Counter preload so a multiply reaches DONE exactly MUL_LAT cycles after accept
   localparam logic [5:0] MUL_CNT0 = 6'(MUL_LAT - 2);

   logic [2:0]  state_r;
   logic [2:0]  state_nxt_s;
   logic [5:0]  cnt_r;
   logic [2:0]  f3_r;
   logic        neg_a_r;
   logic        neg_b_r;
   logic [31:0] rem_r;
   logic [31:0] quo_r;
   logic [31:0] dvs_r;
   logic [63:0] mul_pipe_r [MUL_LAT-1];
   logic [31:0] result_r;
   logic        done_r;
   logic        busy_r;

   logic        accept_s;
   logic        sgn_a_s;
   logic        sgn_b_s;
   logic [63:0] mul_a_s;
   logic [63:0] mul_b_s;
   logic [63:0] prod_s;
   logic [31:0] mul_sel_s;
   logic [31:0] fix_s;
   logic [31:0] result_nxt_s;
   logic [31:0] step_rem_s;
   logic [31:0] step_quo_s;

   div_step u_div_step (
      .rem     (rem_r),
      .quo     (quo_r),
      .dvs     (dvs_r),
      .rem_nxt (step_rem_s),
      .quo_nxt (step_quo_s)
   );

   // Multiply operand extension and product. Operands are sign/zero-extended to
   // 33 bits per op and then to 64; the low 64 bits of the product are exact.
   always_comb begin
      sgn_a_s = (funct3 == F3_MULH) || (funct3 == F3_MULHSU);
      sgn_b_s = (funct3 == F3_MULH);
      mul_a_s = {{32{sgn_a_s & rs1[31]}}, rs1};
      mul_b_s = {{32{sgn_b_s & rs2[31]}}, rs2};
      prod_s  = mul_a_s * mul_b_s;
   end

   // Result candidates: multiply word select and divide sign fix-up
   always_comb begin
      if (f3_r == F3_MUL) begin
         mul_sel_s = mul_pipe_r[MUL_LAT-2][31:0];
      end else begin
         mul_sel_s = mul_pipe_r[MUL_LAT-2][63:32];
      end
      if (f3_r[1]) begin
         fix_s = neg_a_r ? neg32(rem_r) : rem_r;
      end else begin
         fix_s = (neg_a_r ^ neg_b_r) ? neg32(quo_r) : quo_r;
      end
   end

   // Next-state logic, accept decode and the value loaded into result on entry to DONE
   always_comb begin
      state_nxt_s  = state_r;
      accept_s     = 1'b0;
      result_nxt_s = result_r;
      case (state_r)
         ST_IDLE: begin
            if (start && !flush) begin
               accept_s = 1'b1;
               if (!funct3[2]) begin
                  state_nxt_s = ST_MUL;
               end else if (is_special(funct3, rs1, rs2)) begin
                  state_nxt_s  = ST_DONE;
                  result_nxt_s = special_result(funct3, rs1, rs2);
               end else begin
                  state_nxt_s = ST_DIV;
               end
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_MUL: begin
            if (flush) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == 6'd0) begin
               state_nxt_s  = ST_DONE;
               result_nxt_s = mul_sel_s;
            end else begin
               state_nxt_s = ST_MUL;
            end
         end
         ST_DIV: begin
            if (flush) begin
               state_nxt_s = ST_IDLE;
            end else if (cnt_r == 6'd0) begin
               state_nxt_s = ST_FIX;
            end else begin
               state_nxt_s = ST_DIV;
            end
         end
         ST_FIX: begin
            if (flush) begin
               state_nxt_s = ST_IDLE;
            end else begin
               state_nxt_s  = ST_DONE;
               result_nxt_s = fix_s;
            end
         end
         ST_DONE: begin
            // done already asserted for this instruction; a coincident flush changes nothing
            state_nxt_s = ST_IDLE;
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Stall: low in DONE so the pipeline captures result, killed by flush, and
   // gated by rst so it drops the instant reset is asserted.
   always_comb begin
      if (rst && !flush) begin
         stall_o = accept_s || (state_r == ST_MUL) || (state_r == ST_DIV) || (state_r == ST_FIX);
      end else begin
         stall_o = 1'b0;
      end
   end

   // State register and registered outputs
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_r  <= ST_IDLE;
         busy_r   <= 1'b0;
         done_r   <= 1'b0;
         result_r <= 32'd0;
      end else begin
         state_r <= state_nxt_s;
         busy_r  <= (state_nxt_s != ST_IDLE);
         done_r  <= (state_nxt_s == ST_DONE);
         if (state_nxt_s == ST_DONE) begin
            result_r <= result_nxt_s;
         end else begin
            result_r <= result_r;
         end
      end
   end

   // Operand latch, iteration counter and divider datapath
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         f3_r    <= 3'd0;
         neg_a_r <= 1'b0;
         neg_b_r <= 1'b0;
         rem_r   <= 32'd0;
         quo_r   <= 32'd0;
         dvs_r   <= 32'd0;
         cnt_r   <= 6'd0;
      end else if (accept_s) begin
         // funct3[0]=0 marks the signed divide ops; the flags are unused by multiplies
         f3_r    <= funct3;
         neg_a_r <= ~funct3[0] & rs1[31];
         neg_b_r <= ~funct3[0] & rs2[31];
         quo_r   <= (~funct3[0] & rs1[31]) ? neg32(rs1) : rs1;
         dvs_r   <= (~funct3[0] & rs2[31]) ? neg32(rs2) : rs2;
         rem_r   <= 32'd0;
         cnt_r   <= funct3[2] ? 6'd31 : MUL_CNT0;
      end else if ((state_r == ST_DIV) && !flush) begin
         rem_r <= step_rem_s;
         quo_r <= step_quo_s;
         cnt_r <= (cnt_r == 6'd0) ? 6'd0 : (cnt_r - 6'd1);
      end else if ((state_r == ST_MUL) && !flush) begin
         cnt_r <= (cnt_r == 6'd0) ? 6'd0 : (cnt_r - 6'd1);
      end else begin
         cnt_r <= cnt_r;
      end
   end

   // Multiply product pipeline: stage 0 captures at accept, later stages shift each cycle
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < MUL_LAT - 1; i++) begin
            mul_pipe_r[i] <= 64'd0;
         end
      end else begin
         if (accept_s && !funct3[2]) begin
            mul_pipe_r[0] <= prod_s;
         end else begin
            mul_pipe_r[0] <= mul_pipe_r[0];
         end
         for (int i = 1; i < MUL_LAT - 1; i++) begin
            mul_pipe_r[i] <= mul_pipe_r[i-1];
         end
      end
   end

   assign busy   = busy_r;
   assign done   = done_r;
   assign result = result_r;

endmodule
